instr_sequencer: RTL and testbench

//  Program sequencer for the 8-register processor datapath (A..H, accumulator A).
//  - Holds a small program RAM, fetches instructions in order and drives them onto the datapath instruction bus.
//  - Services IN operands through a valid/ready-style request and captures OP on OUT instructions.
//  - Replaces hand-timed stimulus. Sits between the host/loader and the processor.

---
 rtl/instr_sequencer.sv | 151 +++++++++++++++
 tb/tb_instr_sequencer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Program sequencer for the 8-register datapath: holds a small program RAM,
// steps through it and drives each instruction onto the processor bus.
module instr_sequencer #(
  parameter int ADDR_W      = 4,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [0:7]        prog_data,
  input  logic [ADDR_W:0]   prog_len,
  input  logic              start,
  input  logic              abort,
  input  logic [0:7]        in_data,
  input  logic              in_valid,
  input  logic [0:7]        op,
  output logic              in_req,
  output logic [0:7]        ip,
  output logic [0:7]        instr,
  output logic              instr_valid,
  output logic [ADDR_W-1:0] pc,
  output logic [0:7]        out_data,
  output logic              out_valid,
  output logic              busy,
  output logic              done
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int HW    = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [ADDR_W:0] MAXLEN  = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [HW-1:0]   HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [4:0] OPC_IN  = 5'b00111;
  localparam logic [4:0] OPC_OUT = 5'b11111;

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_IN, ISSUE, FINISH} state_t;

  state_t          state;
  logic [0:7]      mem [DEPTH];
  logic [0:7]      word_q;
  logic [ADDR_W:0] len_q;
  logic [HW-1:0]   hold_cnt;
  logic [0:7]      cur;
  logic [ADDR_W:0] pc_inc;

  assign cur    = mem[pc];
  assign pc_inc = {1'b0, pc} + (ADDR_W + 1)'(1);

  // RAM contents survive reset; writes only land while the sequencer is idle.
  always_ff @(posedge clk) begin
    if (prog_we && state == IDLE) begin
      mem[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      word_q      <= '0;
      len_q       <= '0;
      hold_cnt    <= '0;
      in_req      <= 1'b0;
      ip          <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      pc          <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done      <= 1'b0;
      out_valid <= 1'b0;
      if (abort) begin
        state       <= IDLE;
        busy        <= 1'b0;
        in_req      <= 1'b0;
        instr       <= '0;
        instr_valid <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (prog_len != '0) begin
                len_q <= (prog_len > MAXLEN) ? MAXLEN : prog_len;
                pc    <= '0;
                state <= FETCH;
                busy  <= 1'b1;
              end else begin
                done <= 1'b1;
              end
            end
          end
          FETCH: begin
            word_q   <= cur;
            hold_cnt <= '0;
            if (cur == '0) begin
              state <= FINISH;
              done  <= 1'b1;
            end else if (cur[0:4] == OPC_IN) begin
              state  <= WAIT_IN;
              in_req <= 1'b1;
            end else begin
              state       <= ISSUE;
              instr       <= cur;
              instr_valid <= 1'b1;
            end
          end
          WAIT_IN: begin
            if (in_valid) begin
              ip          <= in_data;
              in_req      <= 1'b0;
              instr       <= word_q;
              instr_valid <= 1'b1;
              state       <= ISSUE;
            end
          end
          ISSUE: begin
            if (hold_cnt == HOLD_LAST) begin
              instr       <= '0;
              instr_valid <= 1'b0;
              // op is sampled on the final hold cycle so the datapath has settled.
              if (word_q[0:4] == OPC_OUT) begin
                out_data  <= op;
                out_valid <= 1'b1;
              end
              if (pc_inc == len_q) begin
                state <= FINISH;
                done  <= 1'b1;
              end else begin
                pc    <= pc_inc[ADDR_W-1:0];
                state <= FETCH;
              end
            end else begin
              hold_cnt <= hold_cnt + HW'(1);
            end
          end
          FINISH: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: a processor model drives op, and a schedule-based
// model predicts every output cycle of each program run.
module tb_instr_sequencer;
  localparam int HOLD = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0, prog_we = 1'b0, start = 1'b0, abort = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [0:7] prog_data = '0;
  logic [4:0] prog_len = '0;
  logic [0:7] in_data = '0;
  logic       in_valid = 1'b0;
  logic [0:7] op;
  logic       in_req, instr_valid, out_valid, busy, done;
  logic [0:7] ip, instr, out_data;
  logic [3:0] pc;

  always #5 clk = ~clk;

  instr_sequencer #(.ADDR_W(4), .HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .op(op), .in_req(in_req), .ip(ip),
    .instr(instr), .instr_valid(instr_valid), .pc(pc), .out_data(out_data),
    .out_valid(out_valid), .busy(busy), .done(done)
  );

  // Datapath ISA: IN r, MOV d,s, ADD s (A += r[s]); A is register 0.
  function automatic logic [7:0][7:0] exec(logic [7:0][7:0] r, logic [7:0] w, logic [7:0] v);
    logic [7:0][7:0] n;
    n = r;
    if (w[7:3] == 5'b00111) n[w[2:0]] = v;
    else if (w[7:6] == 2'b10) n[w[5:3]] = r[w[2:0]];
    else if (w[7:3] == 5'b01111) n[0] = r[0] + r[w[2:0]];
    return n;
  endfunction

  logic [7:0][7:0] pr = '0;
  logic            pv = 1'b0;
  always @(posedge clk) begin
    if (instr_valid && !pv) pr <= exec(pr, instr, ip);
    pv <= instr_valid;
  end
  assign op = pr[0];

  typedef struct packed {
    logic busy, iv, req, done, ov;
    logic [7:0] instr, ip, od;
    logic [3:0] pc;
  } exp_t;

  exp_t            exp_q[$];
  logic [7:0]      pm[16];
  logic [7:0]      m_ip = '0, m_od = '0;
  logic [3:0]      m_pc = '0;
  logic [7:0][7:0] m_r = '0;
  int checks = 0, errors = 0;
  int in_wait = 1, req_cnt = 0;
  logic [7:0] in_value = '0;
  bit feed_en = 1'b1;
  int n_issue = 0, n_ov = 0, n_done = 0, n_f8 = 0, bad_hold = 0, last_req = 0;
  int iv_run = 0, req_run = 0;
  int s_issue, s_ov, s_done, s_f8, s_bad;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(bit b, bit iv, bit rq, bit dn, bit ov, logic [7:0] ins);
    exp_t e;
    e.busy = b; e.iv = iv; e.req = rq; e.done = dn; e.ov = ov;
    e.instr = ins; e.ip = m_ip; e.od = m_od; e.pc = m_pc;
    exp_q.push_back(e);
  endtask

  // Cycle schedule: fetch, w request cycles for IN, HOLD issue cycles, then finish.
  task automatic build(int len, int w, logic [7:0] v);
    int n;
    bit pend;
    logic [7:0] wd;
    pend = 1'b0;
    n = (len > 16) ? 16 : len;
    if (n == 0) begin
      push(0, 0, 0, 1, 0, 8'h00);
      push(0, 0, 0, 0, 0, 8'h00);
      return;
    end
    for (int k = 0; k < n; k++) begin
      wd = pm[k];
      m_pc = 4'(k);
      push(1, 0, 0, 0, pend, 8'h00);
      pend = 1'b0;
      if (wd == 8'h00) break;
      if (wd[7:3] == 5'b00111) begin
        repeat (w) push(1, 0, 1, 0, 0, 8'h00);
        m_ip = v;
      end
      m_r = exec(m_r, wd, m_ip);
      repeat (HOLD) push(1, 1, 0, 0, 0, wd);
      if (wd[7:3] == 5'b11111) begin
        m_od = m_r[0];
        pend = 1'b1;
      end
    end
    push(1, 0, 0, 1, pend, 8'h00);
    push(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic load(int a, logic [7:0] d);
    prog_addr = 4'(a); prog_data = d; prog_we = 1'b1;
    @(posedge clk); #1 prog_we = 1'b0;
    pm[a] = d;
  endtask

  task automatic load_prog1();
    load(0, 8'h38); load(1, 8'h88); load(2, 8'h78); load(3, 8'h79); load(4, 8'hF8);
  endtask

  task automatic snap();
    s_issue = n_issue; s_ov = n_ov; s_done = n_done; s_f8 = n_f8; s_bad = bad_hold;
  endtask

  task automatic run(int len, int w, logic [7:0] v, bit inj);
    int t;
    in_wait = w; in_value = v; feed_en = 1'b1;
    snap();
    prog_len = 5'(len); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    build(len, w, v);
    if (inj) begin
      repeat (3) @(posedge clk);
      #1 start = 1'b1; prog_len = 5'd1; prog_we = 1'b1; prog_addr = 4'd4; prog_data = 8'h00;
      @(posedge clk); #1 start = 1'b0; prog_we = 1'b0;
    end
    t = 0;
    while (exp_q.size() > 0 && t < 600) begin
      @(posedge clk);
      t++;
    end
    if (exp_q.size() > 0) begin
      chk("trace_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_busy"}, busy, 0);     chk({tag, "_iv"}, instr_valid, 0);
    chk({tag, "_instr"}, instr, 0);   chk({tag, "_ip"}, ip, 0);
    chk({tag, "_pc"}, pc, 0);         chk({tag, "_od"}, out_data, 0);
    chk({tag, "_ov"}, out_valid, 0);  chk({tag, "_done"}, done, 0);
    chk({tag, "_req"}, in_req, 0);
  endtask

  initial begin
    int t;
    fork
      forever begin : compare
        exp_t e;
        @(negedge clk);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("busy", busy, e.busy);        chk("instr_valid", instr_valid, e.iv);
          chk("in_req", in_req, e.req);     chk("done", done, e.done);
          chk("out_valid", out_valid, e.ov); chk("instr", instr, e.instr);
          chk("ip", ip, e.ip);              chk("out_data", out_data, e.od);
          chk("pc", pc, e.pc);
        end
      end
      forever begin : feeder
        @(negedge clk);
        if (in_valid) in_valid = 1'b0;
        else if (in_req && feed_en) begin
          req_cnt++;
          if (req_cnt >= in_wait) begin
            in_valid = 1'b1; in_data = in_value; req_cnt = 0;
          end
        end else req_cnt = 0;
      end
      forever begin : monitor
        @(negedge clk);
        if (instr_valid) begin
          if (iv_run == 0) n_issue++;
          iv_run++;
          if (instr == 8'hF8) n_f8++;
        end else begin
          if (iv_run != 0 && iv_run != HOLD) bad_hold++;
          iv_run = 0;
        end
        if (in_req) req_run++;
        else begin
          if (req_run != 0) last_req = req_run;
          req_run = 0;
        end
        if (out_valid) n_ov++;
        if (done) n_done++;
      end
    join_none

    repeat (3) @(posedge clk);
    #1 chk_zero("reset");
    rst_n = 1'b1;
    load_prog1();

    run(5, 1, 8'd24, 0);
    chk("s1_out", out_data, 8'd72);   chk("s1_issues", n_issue - s_issue, 5);
    chk("s1_ov", n_ov - s_ov, 1);     chk("s1_done", n_done - s_done, 1);
    chk("s1_hold", bad_hold - s_bad, 0);

    run(5, 7, 8'd24, 1);
    chk("s2_req_len", last_req, 7);   chk("s2_out", out_data, 8'd72);
    chk("s2_issues", n_issue - s_issue, 5); chk("s2_done", n_done - s_done, 1);

    load(1, 8'h00); load(2, 8'hF8);
    run(3, 1, 8'd24, 0);
    chk("s3_f8", n_f8 - s_f8, 0);     chk("s3_ov", n_ov - s_ov, 0);
    chk("s3_done", n_done - s_done, 1); chk("s3_pc", pc, 1);

    run(0, 1, 8'd0, 0);
    chk("s4_issues", n_issue - s_issue, 0); chk("s4_done", n_done - s_done, 1);

    load_prog1();
    in_wait = 1; in_value = 8'd24; feed_en = 1'b1;
    prog_len = 5'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(instr_valid && pc == 4'd2) && t < 60);
    chk("s5_reach_pc2", t < 60, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("s5_iv", instr_valid, 0);  chk("s5_busy", busy, 0);
    chk("s5_instr", instr, 0);     chk("s5_req", in_req, 0);
    chk("s5_done", done, 0);       chk("s5_pc", pc, 2);
    snap();
    repeat (5) @(posedge clk);
    #1 chk("s5_nodone", n_done - s_done, 0);
    m_pc = 4'd2; m_ip = 8'd24;
    prog_len = 5'd0; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1 start = 1'b0; abort = 1'b0;
    chk("s5_sa_busy", busy, 0);    chk("s5_sa_done", done, 0);
    load(3, 8'h78);
    run(5, 1, 8'd24, 0);
    chk("s5_out", out_data, 8'd96);

    load(0, 8'h38); load(1, 8'h88);
    for (int a = 2; a < 15; a++) load(a, 8'h79);
    load(15, 8'hF8);
    run(31, 1, 8'd5, 0);
    chk("s7_out", out_data, 8'd70);  chk("s7_issues", n_issue - s_issue, 16);
    chk("s7_pc", pc, 15);

    load_prog1();
    feed_en = 1'b0; prog_len = 5'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    t = 0;
    while (!in_req && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("s6_reach_wait", in_req, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 chk_zero("s6");
    rst_n = 1'b1;
    m_ip = '0; m_od = '0; m_pc = '0;
    run(5, 1, 8'd24, 0);
    chk("s6_out", out_data, 8'd72);  chk("s6_issues", n_issue - s_issue, 5);
    chk("s6_ov", n_ov - s_ov, 1);    chk("s6_done", n_done - s_done, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
